imm_encoder: RTL and testbench
==============================

# imm_encoder

Pipelined RV64I instruction-word assembler: the inverse of the core's immediate decode. Takes an instruction format, register/function fields and a 64-bit immediate, range-checks the immediate, and scatters its bits into the correct 32-bit instruction fields. It also expands a 32-bit "load constant" macro into a LUI/ADDIW pair. It sits in front of the debug/self-test instruction injector and the boot trampoline generator, and emits instruction beats over a valid/ready stream.

## Interface
- No parameters (RV64I, XLEN=64 fixed).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_fmt`  in  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=LI32 macro, 6/7 reserved.
- `in_opcode`  in  7  placed in inst[6:0]; ignored for LI32.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register fields, used where the format has them.
- `in_funct3`  in  3  inst[14:12] for I/S/B; ignored for U/J/LI32.
- `in_imm`  in  64  immediate, two's complement.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  beat consumed when `out_valid && out_ready`.
- `out_inst`  out  32  encoded instruction.
- `out_err`  out  1  the immediate or format was illegal; `out_inst`=0.
- `out_last`  out  1  last beat of the request.

## Operation
- Field packing:
  - I: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - U: inst[31:12]=imm[31:12].
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
  - rd is in [11:7], rs1 in [19:15], rs2 in [24:20], and funct3 in [14:12], wherever the format defines them.
- Legality checks:
  - I/S: imm must equal sext(imm[11:0]).
  - B: imm must equal sext(imm[12:0]) and imm[0]=0.
  - U: imm must equal sext(imm[31:0]) and imm[11:0]=0.
  - J: imm must equal sext(imm[20:0]) and imm[0]=0.
  - LI32: imm must equal sext(imm[31:0]).
  - Reserved fmt is always illegal.
- An illegal request produces one beat with `out_err`=1, `out_inst`=0, `out_last`=1.
- LI32 expansion: lo = imm[11:0] (signed), hi = (imm[31:0] + 0x800)[31:12], computed as 32-bit wrap-around.
  - If hi==0: one beat, ADDI rd,x0,lo (opcode 0x13).
  - Else if lo==0: one beat, LUI rd,hi (opcode 0x37).
  - Else: two beats, LUI rd,hi, then ADDIW rd,rd,lo (opcode 0x1B, funct3 0).
  - ADDIW is required so that hi=0x80000 wrap cases yield a correct sign-extended result.
- FSM:
  - IDLE: no beat held.
  - BEAT: output register full, nothing pending.
  - BEAT2: output holds the LUI, and the ADDIW is held in a pending register.
- FSM transitions:
  - Accept in IDLE or BEAT with a single-beat result → BEAT.
  - Accept of a two-beat LI32 → BEAT2.
  - BEAT2 + handshake → BEAT, with the pending register moved to the output and `out_last`=1.
  - BEAT + handshake with no new accept → IDLE.
- `in_ready` = (state==IDLE) || (state==BEAT && out_ready). It is 0 in BEAT2.

## Timing
- Reset values: `out_valid`=0, `out_inst`=0, `out_err`=0, `out_last`=0, state IDLE, pending register cleared.
  - `in_ready`=1 in the first cycle after reset is deasserted.
- Latency: accept at edge N → `out_valid` at N+1. The second LI32 beat appears on the cycle after the first beat handshakes.
- Throughput: one single-beat request per cycle with `out_ready` held high. LI32 two-beat costs 2 cycles.
- Once `out_valid` is asserted, `out_inst`, `out_err` and `out_last` hold stable until the handshake, however long `out_ready` stays low.
- Simultaneous output handshake and new accept in BEAT: the output register loads the new beat on the same edge, with no bubble.
- Reset asserted mid-operation (including in BEAT2) drops all held and pending beats; nothing is emitted afterwards.
- No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally only on state and `out_ready`.

## Test plan
- I: opcode 0x13, rd=1, rs1=0, funct3=0, imm=-1 → one beat 0xFFF00093, `out_err`=0, `out_last`=1, one cycle after accept.
- B: opcode 0x63, funct3=0, rs1=1, rs2=2, imm=-4 → 0xFE208EE3. The same request with imm=3 → `out_err`=1, `out_inst`=0.
- J: opcode 0x6F, rd=1, imm=0x800 → 0x001000EF. With imm=0x100000 (out of range) → `out_err`=1.
- LI32: rd=5, imm=0x12345FFF → beats 0x123462B7 (`out_last`=0), then 0xFFF2829B (`out_last`=1). With imm=0x12345000 → single 0x123452B7. With imm=0x7FF → single ADDI 0x7FF00293.
- Backpressure: hold `out_ready`=0 for 5 cycles during an LI32 → first beat stable, `in_ready`=0 throughout. Then stream 8 back-to-back I requests with `out_ready`=1 → 8 beats in 8 consecutive cycles.
- Reset pulsed while in BEAT2 → next cycle `out_valid`=0, `in_ready`=1, and no ADDIW beat ever appears.

Source files
------------

// File: rtl/imm_encoder_if.sv
// ============================================================================
// Module      : imm_encoder_if
// Description : Request/beat stream bundle for the RV64I instruction assembler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err, out_last
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err, out_last
    );
endinterface

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// Module      : imm_encoder
// Description : Pipelined RV64I immediate encoder with LI32 -> LUI/ADDIW expansion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder (
    input  wire logic    clk,
    input  wire logic    reset,
    imm_encoder_if.slave bus
);
    localparam logic [6:0] c_OP_ADDI  = 7'h13;
    localparam logic [6:0] c_OP_LUI   = 7'h37;
    localparam logic [6:0] c_OP_ADDIW = 7'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT  = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pend_q, pend_d;
    logic        err_q, err_d;
    logic        last_q, last_d;

    logic [63:0] w_imm;
    logic        w_fits12, w_fits13, w_fits21, w_fits32;
    logic [31:0] w_li_sum;
    logic [19:0] w_li_hi;
    logic [11:0] w_li_lo;
    logic        w_legal, w_two;
    logic [31:0] w_inst, w_inst2;
    logic        w_in_ready, w_accept;

    assign w_imm    = bus.in_imm;
    assign w_fits12 = (w_imm == {{52{w_imm[11]}}, w_imm[11:0]});
    assign w_fits13 = (w_imm == {{51{w_imm[12]}}, w_imm[12:0]});
    assign w_fits21 = (w_imm == {{43{w_imm[20]}}, w_imm[20:0]});
    assign w_fits32 = (w_imm == {{32{w_imm[31]}}, w_imm[31:0]});

    // Rounding by 0x800 pre-compensates for ADDIW sign-extending its 12-bit operand.
    assign w_li_lo  = w_imm[11:0];
    assign w_li_sum = w_imm[31:0] + 32'h0000_0800;
    assign w_li_hi  = w_li_sum[31:12];

    always_comb begin
        w_legal = 1'b0;
        w_two   = 1'b0;
        w_inst  = 32'd0;
        w_inst2 = 32'd0;
        case (bus.in_fmt)
            3'd0: begin
                w_legal = w_fits12;
                w_inst  = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            3'd1: begin
                w_legal = w_fits12;
                w_inst  = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
            end
            3'd2: begin
                w_legal = w_fits13 && !w_imm[0];
                w_inst  = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           w_imm[4:1], w_imm[11], bus.in_opcode};
            end
            3'd3: begin
                w_legal = w_fits32 && (w_imm[11:0] == 12'd0);
                w_inst  = {w_imm[31:12], bus.in_rd, bus.in_opcode};
            end
            3'd4: begin
                w_legal = w_fits21 && !w_imm[0];
                w_inst  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
            end
            3'd5: begin
                w_legal = w_fits32;
                if (w_li_hi == 20'd0) begin
                    w_inst = {w_li_lo, 5'd0, 3'd0, bus.in_rd, c_OP_ADDI};
                end else if (w_li_lo == 12'd0) begin
                    w_inst = {w_li_hi, bus.in_rd, c_OP_LUI};
                end else begin
                    w_two   = 1'b1;
                    w_inst  = {w_li_hi, bus.in_rd, c_OP_LUI};
                    w_inst2 = {w_li_lo, bus.in_rd, 3'd0, bus.in_rd, c_OP_ADDIW};
                end
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_two   = 1'b0;
            w_inst  = 32'd0;
            w_inst2 = 32'd0;
        end
    end

    assign w_in_ready = (state_q == IDLE) || ((state_q == BEAT) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pend_d  = pend_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            IDLE, BEAT: begin
                if (w_accept) begin
                    inst_d  = w_inst;
                    pend_d  = w_inst2;
                    err_d   = !w_legal;
                    last_d  = !w_two;
                    state_d = w_two ? BEAT2 : BEAT;
                end else if ((state_q == BEAT) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            BEAT2: begin
                if (bus.out_ready) begin
                    inst_d  = pend_q;
                    pend_d  = 32'd0;
                    err_d   = 1'b0;
                    last_d  = 1'b1;
                    state_d = BEAT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inst_q  <= 32'd0;
            pend_q  <= 32'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_inst  = inst_q;
    assign bus.out_err   = err_q;
    assign bus.out_last  = last_q;
endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_encoder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_inst [2];
    logic        m_err;

    function automatic longint fld(input logic [63:0] v, input int hi, input int lo);
        return longint'((v >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1));
    endfunction

    // Reference: range checks on the signed value, fields pulled out by shift/mask.
    function automatic int model(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [63:0] imm);
        longint s, w, lo, hi, r_d, r_s1, r_s2, f, o;
        bit     ok;
        int     n;
        s = imm; r_d = rd; r_s1 = rs1; r_s2 = rs2; f = f3; o = op;
        n = 1; ok = 0; w = 0; m_err = 0; m_inst[1] = 32'd0;
        case (fmt)
            3'd0: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (fld(imm, 11, 0) << 20) + (r_s1 << 15) + (f << 12) + (r_d << 7) + o;
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (fld(imm, 11, 5) << 25) + (r_s2 << 20) + (r_s1 << 15) + (f << 12)
                   + (fld(imm, 4, 0) << 7) + o;
            end
            3'd2: begin
                ok = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
                w  = (fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + (r_s2 << 20) + (r_s1 << 15)
                   + (f << 12) + (fld(imm, 4, 1) << 8) + (fld(imm, 11, 11) << 7) + o;
            end
            3'd3: begin
                ok = (s >= -64'sd2147483648) && (s <= 64'sd2147483647) && (fld(imm, 11, 0) == 0);
                w  = (fld(imm, 31, 12) << 12) + (r_d << 7) + o;
            end
            3'd4: begin
                ok = (s >= -64'sd1048576) && (s <= 64'sd1048575) && (imm[0] == 1'b0);
                w  = (fld(imm, 20, 20) << 31) + (fld(imm, 10, 1) << 21) + (fld(imm, 11, 11) << 20)
                   + (fld(imm, 19, 12) << 12) + (r_d << 7) + o;
            end
            3'd5: begin
                ok = (s >= -64'sd2147483648) && (s <= 64'sd2147483647);
                lo = s & 64'hFFF;
                if (lo >= 2048) lo = lo - 4096;
                hi = ((s - lo) >>> 12) & 64'hFFFFF;
                if (hi == 0) begin
                    w = ((lo & 64'hFFF) << 20) + (r_d << 7) + 64'h13;
                end else if (lo == 0) begin
                    w = (hi << 12) + (r_d << 7) + 64'h37;
                end else begin
                    n = 2;
                    w = (hi << 12) + (r_d << 7) + 64'h37;
                    m_inst[1] = 32'(((lo & 64'hFFF) << 20) + (r_d << 15) + (r_d << 7) + 64'h1B);
                end
            end
            default: ok = 0;
        endcase
        m_inst[0] = 32'(w);
        if (!ok) begin
            n = 1;
            m_err = 1'b1;
            m_inst[0] = 32'd0;
            m_inst[1] = 32'd0;
        end
        return n;
    endfunction

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [63:0] imm);
        bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_imm = imm;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_req;
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (bus.in_ready === 1'b1) done = 1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL send_req timeout: in_ready never 1");
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.out_valid, bus.out_err, bus.out_last} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags got %b want 000", {bus.out_valid, bus.out_err, bus.out_last});
        end
        n_checks++;
        if (bus.out_inst !== 32'd0) begin
            n_errors++; $display("FAIL reset_inst got %h want 0", bus.out_inst);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [63:0] imm;
        logic [1:0]  n;
        logic [31:0] b0;
        logic [31:0] b1;
        logic        err;
    } vec_t;

    task automatic test_directed;
        vec_t v [15];
        v[0]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 32'hFFF00093, 32'd0, 1'b0};
        v[1]  = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 32'hFE208EE3, 32'd0, 1'b0};
        v[2]  = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 64'd3,                   2'd1, 32'h0,        32'd0, 1'b1};
        v[3]  = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 64'h800,                 2'd1, 32'h001000EF, 32'd0, 1'b0};
        v[4]  = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 64'h100000,              2'd1, 32'h0,        32'd0, 1'b1};
        v[5]  = '{3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345FFF,            2'd2, 32'h123462B7, 32'hFFF2829B, 1'b0};
        v[6]  = '{3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345000,            2'd1, 32'h123452B7, 32'd0, 1'b0};
        v[7]  = '{3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h7FF,                 2'd1, 32'h7FF00293, 32'd0, 1'b0};
        v[8]  = '{3'd3, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_8000_0000, 2'd1, 32'h800000B7, 32'd0, 1'b0};
        v[9]  = '{3'd3, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 64'h8000_0000,           2'd1, 32'h0,        32'd0, 1'b1};
        v[10] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2047,                2'd1, 32'h7FF00093, 32'd0, 1'b0};
        v[11] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048,                2'd1, 32'h0,        32'd0, 1'b1};
        v[12] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd0,                   2'd1, 32'h0,        32'd0, 1'b1};
        v[13] = '{3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h7FFFF800,            2'd2, 32'h800002B7, 32'h8002829B, 1'b0};
        v[14] = '{3'd1, 7'h23, 5'd0, 5'd2, 5'd1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 2'd1, 32'hFE113C23, 32'd0, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(v[i].fmt, v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].imm);
            send_req();
            for (int b = 0; b < int'(v[i].n); b++) begin
                logic [31:0] want;
                want = (b == 0) ? v[i].b0 : v[i].b1;
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_inst !== want) begin
                    n_errors++;
                    $display("FAIL dir%0d beat%0d got v=%b inst=%h want v=1 inst=%h", i, b, bus.out_valid, bus.out_inst, want);
                end
                n_checks++;
                if (bus.out_err !== v[i].err || bus.out_last !== (b == int'(v[i].n) - 1)) begin
                    n_errors++;
                    $display("FAIL dir%0d flags%0d got err=%b last=%b want err=%b last=%b", i, b,
                             bus.out_err, bus.out_last, v[i].err, (b == int'(v[i].n) - 1));
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_errors++; $display("FAIL dir%0d extra_beat got out_valid=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_q [$];
        int n;
        bus.out_ready = 1'b0;
        drive(3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345FFF);
        send_req();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h123462B7 || bus.out_last !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold%0d got v=%b inst=%h last=%b want 1 123462b7 0", c, bus.out_valid, bus.out_inst, bus.out_last);
            end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_errors++; $display("FAIL bp_in_ready%0d got %b want 0", c, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'hFFF2829B || bus.out_last !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_beat2 got v=%b inst=%h last=%b want 1 fff2829b 1", bus.out_valid, bus.out_inst, bus.out_last);
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                drive(3'd0, 7'h13, 5'(i + 1), 5'(i), 5'd0, 3'(i), 64'(longint'(i * 100 - 300)));
                bus.in_valid = 1'b1;
                n = model(3'd0, 7'h13, 5'(i + 1), 5'(i), 5'd0, 3'(i), 64'(longint'(i * 100 - 300)));
                exp_q.push_back(m_inst[0]);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (i < 8) begin
                n_checks++;
                if (bus.in_ready !== 1'b1) begin
                    n_errors++; $display("FAIL b2b_in_ready%0d got %b want 1", i, bus.in_ready);
                end
            end
            if (i > 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_inst !== exp_q[0] || bus.out_last !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_beat%0d got v=%b inst=%h want v=1 inst=%h", i - 1, bus.out_valid, bus.out_inst, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || n != 1) begin
            n_errors++; $display("FAIL b2b_drain got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_beat2;
        bus.out_ready = 1'b0;
        drive(3'd5, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 64'h0ABCD123);
        send_req();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
            n_errors++; $display("FAIL rst_pre got v=%b last=%b want 1 0", bus.out_valid, bus.out_last);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_post got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_errors++; $display("FAIL rst_ghost%0d got out_valid=%b want 0", c, bus.out_valid);
            end
        end
    endtask

    // Queue of outstanding beats: its depth stands in for the encoder's occupancy.
    task automatic test_random;
        logic [33:0] q [$];
        logic [33:0] held, got;
        bit          have_req, was_held;
        logic [2:0]  fmt;
        logic [63:0] raw, imm;
        int          w, n;
        int          widths [7] = '{5, 12, 13, 21, 32, 33, 64};
        have_req = 0; was_held = 0; held = '0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!have_req && ($urandom % 4 != 0)) begin
                fmt = ($urandom % 12 == 0) ? 3'(6 + $urandom % 2) : 3'($urandom % 6);
                w   = widths[$urandom % 7];
                raw = {$urandom, $urandom};
                imm = (w < 64) ? 64'($signed(raw << (64 - w)) >>> (64 - w)) : raw;
                if ($urandom % 2 == 0) imm[0] = 1'b0;
                if ($urandom % 4 == 0) imm[11:0] = 12'd0;
                drive(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
                have_req = 1;
            end
            bus.in_valid  = have_req;
            bus.out_ready = ($urandom % 3 != 0);
            #1;
            n_checks++;
            if (bus.out_valid !== (q.size() != 0)) begin
                n_errors++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, bus.out_valid, q.size() != 0);
            end
            n_checks++;
            if (bus.in_ready !== (q.size() == 0 || (q.size() == 1 && bus.out_ready))) begin
                n_errors++; $display("FAIL rnd_in_ready cyc%0d got %b depth %0d", cyc, bus.in_ready, q.size());
            end
            got = {bus.out_err, bus.out_last, bus.out_inst};
            if (was_held) begin
                n_checks++;
                if (got !== held) begin
                    n_errors++; $display("FAIL rnd_stable cyc%0d got %h want %h", cyc, got, held);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready && q.size() > 0) begin
                n_checks++;
                if (got !== q[0]) begin
                    n_errors++; $display("FAIL rnd_beat cyc%0d got %h want %h", cyc, got, q[0]);
                end
                void'(q.pop_front());
            end
            was_held = (bus.out_valid === 1'b1) && !bus.out_ready;
            held = got;
            if (have_req && bus.in_ready === 1'b1) begin
                n = model(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3, bus.in_imm);
                for (int b = 0; b < n; b++) q.push_back({m_err, (b == n - 1), m_inst[b]});
                have_req = 0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5 && q.size() > 0; c++) begin
            #1;
            n_checks++;
            got = {bus.out_err, bus.out_last, bus.out_inst};
            if (bus.out_valid !== 1'b1 || got !== q[0]) begin
                n_errors++; $display("FAIL rnd_drain got v=%b %h want %h", bus.out_valid, got, q[0]);
            end
            void'(q.pop_front());
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || q.size() != 0) begin
            n_errors++; $display("FAIL rnd_end got out_valid=%b left %0d want 0 0", bus.out_valid, q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_beat2();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
